// File: rtl/rx_frame_buffer_if.sv
// Bundles the RX byte stream, the random-access read port and the statistics of rx_frame_buffer.
// The slave modport is the buffer; the master modport is the upstream source plus the frame reader.
interface rx_frame_buffer_if #(
  parameter int ADDR_W = 7,
  parameter int CNT_W  = 16
);
  logic [7:0]        rx_data;
  logic              rx_byte_tgl;
  logic              rx_frame_active;
  logic              rx_crc_ok;
  logic [ADDR_W-1:0] rd_addr;
  logic [7:0]        rd_data;
  logic              frame_ready;
  logic [ADDR_W:0]   frame_len;
  logic              frame_release;
  logic [CNT_W-1:0]  frame_count;
  logic [CNT_W-1:0]  drop_crc_count;
  logic [CNT_W-1:0]  drop_ovf_count;
  logic [CNT_W-1:0]  drop_busy_count;

  modport slave (
    input  rx_data, rx_byte_tgl, rx_frame_active, rx_crc_ok, rd_addr, frame_release,
    output rd_data, frame_ready, frame_len,
           frame_count, drop_crc_count, drop_ovf_count, drop_busy_count
  );

  modport master (
    output rx_data, rx_byte_tgl, rx_frame_active, rx_crc_ok, rd_addr, frame_release,
    input  rd_data, frame_ready, frame_len,
           frame_count, drop_crc_count, drop_ovf_count, drop_busy_count
  );
endinterface

// File: rtl/rx_frame_buffer.sv
// Two-bank ping-pong frame buffer: stores RX frames, commits CRC-good ones and presents them in
// commit order to a random-access reader that frees each bank with a release pulse.
module rx_frame_buffer #(
  parameter int ADDR_W = 7,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  rx_frame_buffer_if.slave  bus
);
  localparam int DEPTH = 2**ADDR_W;
  localparam logic [ADDR_W:0] FULL_PTR = {1'b1, {ADDR_W{1'b0}}};

  typedef enum logic [1:0] {IDLE, RECV, DROP} state_t;

  state_t                 r_state;
  logic                   r_tgl_q;
  logic                   r_fa_q;
  logic [ADDR_W:0]        r_wr_ptr;
  logic                   r_wr_bank;
  logic                   r_rd_bank;
  logic [1:0]             r_full;
  logic [1:0][ADDR_W:0]   r_len;
  logic [7:0]             r_mem [2*DEPTH];
  logic [7:0]             r_rd_data;
  logic [CNT_W-1:0]       r_frame_cnt;
  logic [CNT_W-1:0]       r_crc_cnt;
  logic [CNT_W-1:0]       r_ovf_cnt;
  logic [CNT_W-1:0]       r_busy_cnt;

  logic                   w_strobe;
  logic                   w_start;
  logic                   w_end;
  logic                   w_release;
  logic                   w_ovf;
  logic                   w_wr_en;
  logic                   w_commit;
  logic [ADDR_W:0]        w_ptr_after;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  assign w_strobe    = bus.rx_byte_tgl ^ r_tgl_q;
  assign w_start     = bus.rx_frame_active & ~r_fa_q;
  assign w_end       = ~bus.rx_frame_active & r_fa_q;
  assign w_release   = bus.frame_release & r_full[r_rd_bank];
  assign w_ovf       = (r_state == RECV) && w_strobe && (r_wr_ptr == FULL_PTR);
  assign w_wr_en     = (r_state == RECV) && w_strobe && !w_ovf;
  assign w_ptr_after = r_wr_ptr + {{ADDR_W{1'b0}}, w_wr_en};
  // A byte arriving with the frame end is counted in the length before the verdict is taken.
  assign w_commit    = (r_state == RECV) && w_end && !w_ovf && bus.rx_crc_ok && (w_ptr_after != '0);

  // Loading live inputs during reset too means a frame already in flight never produces a start.
  always_ff @(posedge clk) begin
    r_tgl_q <= bus.rx_byte_tgl;
    r_fa_q  <= bus.rx_frame_active;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= IDLE;
      r_wr_ptr    <= '0;
      r_wr_bank   <= 1'b0;
      r_rd_bank   <= 1'b0;
      r_full      <= '0;
      r_len       <= '0;
      r_frame_cnt <= '0;
      r_crc_cnt   <= '0;
      r_ovf_cnt   <= '0;
      r_busy_cnt  <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_start) begin
            if (!r_full[0]) begin
              r_state   <= RECV;
              r_wr_bank <= 1'b0;
              r_wr_ptr  <= '0;
            end else if (!r_full[1]) begin
              r_state   <= RECV;
              r_wr_bank <= 1'b1;
              r_wr_ptr  <= '0;
            end else begin
              r_state    <= DROP;
              r_busy_cnt <= sat_inc(r_busy_cnt);
            end
          end
        end
        RECV: begin
          if (w_ovf) begin
            r_ovf_cnt <= sat_inc(r_ovf_cnt);
            // An overflow on the final byte must not leave us waiting in DROP for an end already seen.
            r_state   <= w_end ? IDLE : DROP;
          end else begin
            r_wr_ptr <= w_ptr_after;
            if (w_end) begin
              r_state <= IDLE;
              if (w_commit) begin
                r_len[r_wr_bank] <= w_ptr_after;
                r_frame_cnt      <= sat_inc(r_frame_cnt);
              end else begin
                r_crc_cnt <= sat_inc(r_crc_cnt);
              end
            end
          end
        end
        DROP: begin
          if (w_end) r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase

      // rd_bank always points at the oldest full bank; a commit into an empty buffer claims it.
      if (w_release) begin
        r_full[r_rd_bank] <= 1'b0;
        r_rd_bank         <= ~r_rd_bank;
      end else if (w_commit && !r_full[r_rd_bank]) begin
        r_rd_bank <= r_wr_bank;
      end
      if (w_commit) r_full[r_wr_bank] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_wr_en) r_mem[{r_wr_bank, r_wr_ptr[ADDR_W-1:0]}] <= bus.rx_data;
  end

  always_ff @(posedge clk) begin
    if (reset) r_rd_data <= '0;
    else       r_rd_data <= r_mem[{r_rd_bank, bus.rd_addr}];
  end

  assign bus.rd_data         = r_rd_data;
  assign bus.frame_ready     = r_full[r_rd_bank];
  assign bus.frame_len       = r_len[r_rd_bank];
  assign bus.frame_count     = r_frame_cnt;
  assign bus.drop_crc_count  = r_crc_cnt;
  assign bus.drop_ovf_count  = r_ovf_cnt;
  assign bus.drop_busy_count = r_busy_cnt;
endmodule

// File: tb/tb_rx_frame_buffer.sv
// Scenario-driven bench for rx_frame_buffer: committed frames are queued when sent and
// checked byte by byte when the reader drains them.
module tb_rx_frame_buffer;
  localparam int ADDR_W = 7;
  localparam int CNT_W  = 16;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  rx_frame_buffer_if #(.ADDR_W(ADDR_W), .CNT_W(CNT_W)) bus();

  rx_frame_buffer #(.ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus.slave)
  );

  typedef struct {
    int         len;
    logic [7:0] base;
  } frame_t;

  frame_t sb[$];
  int tests_run    = 0;
  int tests_failed = 0;
  int exp_frames, exp_crc, exp_ovf, exp_busy;
  logic ready_before;

  task automatic step(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step(3);
    reset = 1'b0;
    sb.delete();
    exp_frames = 0; exp_crc = 0; exp_ovf = 0; exp_busy = 0;
  endtask

  // Sends one frame; rel pulses frame_release in the frame-end cycle.
  task automatic send_frame(input int len, input logic [7:0] base, input logic crc,
                            input bit coincident, input bit push, input bit rel);
    frame_t f;
    bus.rx_frame_active = 1'b1;
    bus.rx_crc_ok       = crc;
    step();
    for (int i = 0; i < len; i++) begin
      bus.rx_data     = base + 8'(i);
      bus.rx_byte_tgl = ~bus.rx_byte_tgl;
      if (!(coincident && i == len - 1)) step();
    end
    bus.rx_frame_active = 1'b0;
    bus.frame_release   = rel;
    ready_before        = bus.frame_ready;
    step();
    bus.frame_release = 1'b0;
    if (push) begin
      f.len  = len;
      f.base = base;
      sb.push_back(f);
    end
    $display("[TB] sent frame len=%0d base=%02h crc=%0b coincident=%0b", len, base, crc, coincident);
  endtask

  task automatic read_and_release(input string name);
    frame_t     f;
    int         t = 0;
    int         errs = 0;
    int         bad_i = 0;
    logic [7:0] got_b = '0;
    logic [7:0] exp_b;
    while (!bus.frame_ready && t < 50) begin
      step();
      t++;
    end
    tests_run++;
    if (bus.frame_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL %s_ready_timeout: frame_ready=%b, required 1 within 50 cycles", name, bus.frame_ready);
      return;
    end
    tests_run++;
    if (sb.size() == 0) begin
      tests_failed++;
      $display("FAIL %s_unexpected: frame_len=%0d presented, required no frame", name, bus.frame_len);
      return;
    end
    f = sb.pop_front();
    tests_run++;
    if (bus.frame_len !== (ADDR_W+1)'(f.len)) begin
      tests_failed++;
      $display("FAIL %s_len: frame_len=%0d, required %0d", name, bus.frame_len, f.len);
    end
    for (int i = 0; i < f.len; i++) begin
      bus.rd_addr = ADDR_W'(i);
      step();
      exp_b = f.base + 8'(i);
      if (bus.rd_data !== exp_b) begin
        if (errs == 0) begin
          bad_i = i;
          got_b = bus.rd_data;
        end
        errs++;
      end
    end
    tests_run++;
    if (errs != 0) begin
      tests_failed++;
      $display("FAIL %s_data: %0d bad bytes, first at %0d rd_data=%02h, required %02h",
               name, errs, bad_i, got_b, f.base + 8'(bad_i));
    end
    bus.frame_release = 1'b1;
    step();
    bus.frame_release = 1'b0;
    $display("[TB] %s: read frame len=%0d base=%02h and released", name, f.len, f.base);
  endtask

  task automatic test_reset();
    do_reset();
    tests_run++;
    if ({bus.frame_ready, bus.frame_len, bus.rd_data} !== '0) begin
      tests_failed++;
      $display("FAIL reset_outputs: ready=%b len=%0d rd_data=%02h, required 0 0 00",
               bus.frame_ready, bus.frame_len, bus.rd_data);
    end
    tests_run++;
    if ({bus.frame_count, bus.drop_crc_count, bus.drop_ovf_count, bus.drop_busy_count} !== '0) begin
      tests_failed++;
      $display("FAIL reset_counters: %0d %0d %0d %0d, required all 0", bus.frame_count,
               bus.drop_crc_count, bus.drop_ovf_count, bus.drop_busy_count);
    end
    $display("[TB] test_reset done");
  endtask

  task automatic test_good_frame();
    send_frame(60, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0);
    exp_frames++;
    tests_run++;
    if (ready_before !== 1'b0 || bus.frame_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL t1_latency: ready before/after end edge=%b/%b, required 0/1", ready_before, bus.frame_ready);
    end
    bus.rd_addr = 7'd5;
    step();
    tests_run++;
    if (bus.rd_data !== 8'h05) begin
      tests_failed++;
      $display("FAIL t1_rd_addr5: rd_data=%02h, required 05", bus.rd_data);
    end
    tests_run++;
    if (bus.frame_count !== CNT_W'(exp_frames)) begin
      tests_failed++;
      $display("FAIL t1_frame_count: %0d, required %0d", bus.frame_count, exp_frames);
    end
    read_and_release("t1");
  endtask

  task automatic test_crc_drop();
    send_frame(60, 8'h10, 1'b0, 1'b0, 1'b0, 1'b0);
    exp_crc++;
    step(2);
    tests_run++;
    if (bus.frame_ready !== 1'b0) begin
      tests_failed++;
      $display("FAIL t2_bad_crc_ready: frame_ready=%b, required 0", bus.frame_ready);
    end
    send_frame(0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0);
    exp_crc++;
    send_frame(20, 8'h40, 1'b1, 1'b0, 1'b1, 1'b0);
    exp_frames++;
    tests_run++;
    if ({bus.frame_count, bus.drop_crc_count, bus.drop_ovf_count, bus.drop_busy_count} !==
        {CNT_W'(exp_frames), CNT_W'(exp_crc), CNT_W'(exp_ovf), CNT_W'(exp_busy)}) begin
      tests_failed++;
      $display("FAIL t2_counters: %0d %0d %0d %0d, required %0d %0d %0d %0d", bus.frame_count,
               bus.drop_crc_count, bus.drop_ovf_count, bus.drop_busy_count,
               exp_frames, exp_crc, exp_ovf, exp_busy);
    end
    read_and_release("t2");
  endtask

  task automatic test_overflow();
    send_frame(129, 8'h20, 1'b1, 1'b0, 1'b0, 1'b0);
    exp_ovf++;
    step();
    tests_run++;
    if (bus.frame_ready !== 1'b0) begin
      tests_failed++;
      $display("FAIL t3_ovf_ready: frame_ready=%b, required 0", bus.frame_ready);
    end
    send_frame(128, 8'h80, 1'b1, 1'b0, 1'b1, 1'b0);
    send_frame(64, 8'h33, 1'b1, 1'b0, 1'b1, 1'b0);
    exp_frames += 2;
    tests_run++;
    if ({bus.frame_count, bus.drop_crc_count, bus.drop_ovf_count, bus.drop_busy_count} !==
        {CNT_W'(exp_frames), CNT_W'(exp_crc), CNT_W'(exp_ovf), CNT_W'(exp_busy)}) begin
      tests_failed++;
      $display("FAIL t3_counters: %0d %0d %0d %0d, required %0d %0d %0d %0d", bus.frame_count,
               bus.drop_crc_count, bus.drop_ovf_count, bus.drop_busy_count,
               exp_frames, exp_crc, exp_ovf, exp_busy);
    end
    read_and_release("t3_max");
    read_and_release("t3_64");
  endtask

  task automatic test_busy_order();
    send_frame(10, 8'h01, 1'b1, 1'b0, 1'b1, 1'b0);
    send_frame(20, 8'h51, 1'b1, 1'b0, 1'b1, 1'b0);
    send_frame(30, 8'hA1, 1'b1, 1'b0, 1'b0, 1'b0);
    exp_frames += 2;
    exp_busy++;
    tests_run++;
    if ({bus.frame_count, bus.drop_crc_count, bus.drop_ovf_count, bus.drop_busy_count} !==
        {CNT_W'(exp_frames), CNT_W'(exp_crc), CNT_W'(exp_ovf), CNT_W'(exp_busy)}) begin
      tests_failed++;
      $display("FAIL t4_counters: %0d %0d %0d %0d, required %0d %0d %0d %0d", bus.frame_count,
               bus.drop_crc_count, bus.drop_ovf_count, bus.drop_busy_count,
               exp_frames, exp_crc, exp_ovf, exp_busy);
    end
    read_and_release("t4_first");
    read_and_release("t4_second");
    tests_run++;
    if (bus.frame_ready !== 1'b0) begin
      tests_failed++;
      $display("FAIL t4_empty: frame_ready=%b, required 0", bus.frame_ready);
    end
  endtask

  task automatic test_back_to_back();
    send_frame(16, 8'h60, 1'b1, 1'b1, 1'b1, 1'b0);
    exp_frames++;
    read_and_release("t5_coincident");
    send_frame(8, 8'h70, 1'b1, 1'b0, 1'b0, 1'b0);
    exp_frames++;
    tests_run++;
    if (bus.frame_len !== 8'd8) begin
      tests_failed++;
      $display("FAIL t5_first_len: frame_len=%0d, required 8", bus.frame_len);
    end
    send_frame(12, 8'hC0, 1'b1, 1'b0, 1'b1, 1'b1);
    exp_frames++;
    tests_run++;
    if (bus.frame_ready !== 1'b1 || bus.frame_len !== 8'd12) begin
      tests_failed++;
      $display("FAIL t5_release_commit: ready=%b len=%0d, required 1 12", bus.frame_ready, bus.frame_len);
    end
    read_and_release("t5_after_release");
    tests_run++;
    if (bus.frame_ready !== 1'b0 || bus.frame_count !== CNT_W'(exp_frames)) begin
      tests_failed++;
      $display("FAIL t5_final: ready=%b frame_count=%0d, required 0 %0d",
               bus.frame_ready, bus.frame_count, exp_frames);
    end
  endtask

  task automatic test_reset_mid_frame();
    bus.rx_frame_active = 1'b1;
    bus.rx_crc_ok       = 1'b1;
    step();
    for (int i = 0; i < 5; i++) begin
      bus.rx_data     = 8'(i);
      bus.rx_byte_tgl = ~bus.rx_byte_tgl;
      step();
    end
    reset = 1'b1;
    step(2);
    reset = 1'b0;
    sb.delete();
    exp_frames = 0; exp_crc = 0; exp_ovf = 0; exp_busy = 0;
    for (int i = 0; i < 3; i++) begin
      bus.rx_data     = 8'(i);
      bus.rx_byte_tgl = ~bus.rx_byte_tgl;
      step();
    end
    bus.rx_frame_active = 1'b0;
    step(3);
    $display("[TB] t6: reset applied mid-frame");
    tests_run++;
    if ({bus.frame_ready, bus.frame_count, bus.drop_crc_count, bus.drop_ovf_count, bus.drop_busy_count} !== '0) begin
      tests_failed++;
      $display("FAIL t6_after_reset: ready=%b counts %0d %0d %0d %0d, required 0 and all 0",
               bus.frame_ready, bus.frame_count, bus.drop_crc_count, bus.drop_ovf_count, bus.drop_busy_count);
    end
    send_frame(30, 8'h90, 1'b1, 1'b0, 1'b1, 1'b0);
    exp_frames++;
    tests_run++;
    if (bus.frame_count !== CNT_W'(exp_frames)) begin
      tests_failed++;
      $display("FAIL t6_frame_count: %0d, required %0d", bus.frame_count, exp_frames);
    end
    read_and_release("t6");
  endtask

  initial begin
    reset               = 1'b1;
    bus.rx_data         = '0;
    bus.rx_byte_tgl     = 1'b0;
    bus.rx_frame_active = 1'b0;
    bus.rx_crc_ok       = 1'b0;
    bus.rd_addr         = '0;
    bus.frame_release   = 1'b0;
    test_reset();
    test_good_frame();
    test_crc_drop();
    test_overflow();
    test_busy_order();
    test_back_to_back();
    test_reset_mid_frame();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end
endmodule
